led_blink_multi: RTL and testbench

Multi-channel, fabric-logic LED blinker that replaces a fixed chain of hard clock-divider primitives with a single-clock prescaler and per-channel programmable counters. Each channel independently drives an LED as off, square-wave toggle, fixed-brightness PWM or triangle-ramp "breathe". It sits downstream of the on-chip oscillator/PLL and is configured at run time through a simple write strobe.

---
 rtl/led_blink_multi.sv | 157 +++++++++++++++
 tb/tb_led_blink_multi.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_multi.sv
// led_blink_multi: multi-channel LED blinker with shared prescaler.
// Each channel runs OFF, TOGGLE, PWM or BREATHE from one clock.
module led_blink_multi #(
  parameter int CHANNELS   = 4,
  parameter int PRESCALE   = 27000,
  parameter int CNT_W      = 16,
  parameter int PWM_W      = 8,
  parameter int DEF_PERIOD = 500,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [PWM_W-1:0]    cfg_duty,
  output logic                tick,
  output logic [CHANNELS-1:0] led
);

  typedef enum logic [1:0] {
    M_OFF = 2'b00,
    M_TOG = 2'b01,
    M_PWM = 2'b10,
    M_BRE = 2'b11
  } mode_e;

  localparam int PS_W = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
  localparam logic [PWM_W-1:0] LVL_MAX = '1;
  localparam logic [PWM_W-1:0] DUTY_RST = PWM_W'(1) << (PWM_W - 1);
  localparam logic [CNT_W-1:0] PER_RST = CNT_W'(DEF_PERIOD);

  logic [PS_W-1:0]  p_q, p_d;
  logic             tick_q, tick_d;
  logic [PWM_W-1:0] pc_q, pc_d;

  // Prescaler wrap and free-running PWM frame counter next state.
  always_comb begin
    p_d    = p_q + PS_W'(1);
    tick_d = 1'b0;
    if (p_q == PS_MAX) begin
      p_d    = '0;
      tick_d = 1'b1;
    end
    pc_d = pc_q + PWM_W'(1);
  end

  // Shared timing registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q    <= '0;
      tick_q <= 1'b0;
      pc_q   <= '0;
    end else begin
      p_q    <= p_d;
      tick_q <= tick_d;
      pc_q   <= pc_d;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PWM_W-1:0] level_q, level_d;
    logic             dir_q, dir_d;
    logic             led_q, led_d;
    logic             wr;
    logic             expire;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] cnt_step;

    // Out-of-range channel codes match no instance and are dropped.
    assign wr = cfg_we && (cfg_ch == CH_W'(i));
    assign last = (period_q == '0) ? '0 : period_q - CNT_W'(1);
    assign expire = tick_q && (cnt_q == last);
    assign cnt_step = expire ? '0 : cnt_q + CNT_W'(1);

    // Channel next state; a write takes priority over a tick.
    always_comb begin
      mode_d   = mode_q;
      period_d = period_q;
      duty_d   = duty_q;
      cnt_d    = cnt_q;
      level_d  = level_q;
      dir_d    = dir_q;
      led_d    = led_q;
      if (wr) begin
        mode_d   = mode_e'(cfg_mode);
        period_d = cfg_period;
        duty_d   = cfg_duty;
        cnt_d    = '0;
        level_d  = '0;
        dir_d    = 1'b0;
        led_d    = 1'b0;
      end else begin
        unique case (mode_q)
          M_OFF: begin
            cnt_d = '0;
            led_d = 1'b0;
          end
          M_TOG: begin
            if (tick_q) cnt_d = cnt_step;
            if (expire) led_d = ~led_q;
          end
          M_PWM: begin
            cnt_d = '0;
            led_d = pc_q < duty_q;
          end
          M_BRE: begin
            if (tick_q) cnt_d = cnt_step;
            led_d = pc_q < level_q;
            if (expire) begin
              if (!dir_q) begin
                level_d = level_q + PWM_W'(1);
                if (level_q == LVL_MAX - PWM_W'(1)) dir_d = 1'b1;
              end else begin
                level_d = level_q - PWM_W'(1);
                if (level_q == PWM_W'(1)) dir_d = 1'b0;
              end
            end
          end
          default: led_d = 1'b0;
        endcase
      end
    end

    // Channel registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        mode_q   <= M_TOG;
        period_q <= PER_RST;
        duty_q   <= DUTY_RST;
        cnt_q    <= '0;
        level_q  <= '0;
        dir_q    <= 1'b0;
        led_q    <= 1'b0;
      end else begin
        mode_q   <= mode_d;
        period_q <= period_d;
        duty_q   <= duty_d;
        cnt_q    <= cnt_d;
        level_q  <= level_d;
        dir_q    <= dir_d;
        led_q    <= led_d;
      end
    end

    assign led[i] = led_q;
  end

endmodule

// File: tb/tb_led_blink_multi.sv
// tb_led_blink_multi: directed self-checking bench for led_blink_multi.
// PRESCALE=4, DEF_PERIOD=3, CHANNELS=5 so channel codes 5..7 are invalid.
module tb_led_blink_multi;

  logic        clk;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_period;
  logic [7:0]  cfg_duty;
  logic        tick;
  logic [4:0]  led;

  int nvec;
  int nerr;
  int ecnt;

  led_blink_multi #(
    .CHANNELS(5),
    .PRESCALE(4),
    .CNT_W(16),
    .PWM_W(8),
    .DEF_PERIOD(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode),
    .cfg_period(cfg_period),
    .cfg_duty(cfg_duty),
    .tick(tick),
    .led(led)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @edge %0d: got %0h expected %0h",
               tag, ecnt, got, exp);
    end
  endtask

  task automatic tick_edge();
    @(posedge clk);
    @(negedge clk);
    ecnt++;
  endtask

  task automatic cfg_write(input logic [2:0]  ch,
                           input logic [1:0]  m,
                           input logic [15:0] per,
                           input logic [7:0]  d);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_mode   = m;
    cfg_period = per;
    cfg_duty   = d;
    tick_edge();
    cfg_we = 1'b0;
  endtask

  // Untouched TOGGLE channel, period 3, 4 clk per tick.
  function automatic logic def_tog(input int k);
    return (k >= 13) && ((((k - 13) / 12) % 2) == 0);
  endfunction

  function automatic logic pwm_exp(input int k, input int d);
    return ((k - 1) % 256) < d;
  endfunction

  int duties[3];
  int hi, bad, lvl, w, k, hi_m;
  logic dn, e, l0;

  initial begin
    nvec = 0;
    nerr = 0;
    ecnt = 0;
    clk = 1'b0;
    reset = 1'b1;
    cfg_we = 1'b0;
    cfg_ch = '0;
    cfg_mode = '0;
    cfg_period = '0;
    cfg_duty = '0;
    duties[0] = 64;
    duties[1] = 0;
    duties[2] = 255;

    tick_edge();
    tick_edge();
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    reset = 1'b0;
    ecnt = 0;

    for (int i = 1; i <= 26; i++) begin
      tick_edge();
      chk("tick", 32'(tick), 32'((i % 4) == 0));
      chk("led_def", 32'(led), def_tog(i) ? 32'h1f : 32'h0);
    end

    for (int t = 0; t < 3; t++) begin
      cfg_write(3'd1, 2'b10, 16'd1, 8'(duties[t]));
      hi = 0;
      bad = 0;
      for (int j = 0; j < 256; j++) begin
        tick_edge();
        if (led[1]) hi++;
        if (led[1] != pwm_exp(ecnt, duties[t])) bad++;
        if (led[4:3] != {2{def_tog(ecnt)}}) bad++;
      end
      chk("pwm_high", hi, duties[t]);
      chk("pwm_phase", bad, 0);
    end

    cfg_write(3'd2, 2'b11, 16'd1, 8'd0);
    lvl = 0;
    dn = 1'b0;
    bad = 0;
    hi = 0;
    hi_m = 0;
    for (int j = 0; j < 2100; j++) begin
      k = ecnt + 1;
      e = ((k - 1) % 256) < lvl;
      if (e) hi_m++;
      if (((k - 1) % 4) == 0) begin
        if (!dn) begin
          lvl++;
          if (lvl == 255) dn = 1'b1;
        end else begin
          lvl--;
          if (lvl == 0) dn = 1'b0;
        end
      end
      tick_edge();
      if (led[2]) hi++;
      if (led[2] != e) bad++;
      if (led[1] != pwm_exp(ecnt, 255)) bad++;
      if (led[4:3] != {2{def_tog(ecnt)}}) bad++;
    end
    chk("breathe_trace", bad, 0);
    chk("breathe_high", hi, hi_m);

    cfg_write(3'd0, 2'b01, 16'd0, 8'd0);
    l0 = 1'b0;
    for (int j = 0; j < 24; j++) begin
      k = ecnt + 1;
      if (((k - 1) % 4) == 0) l0 = ~l0;
      if (j == 3 || j == 9 || j == 15) begin
        cfg_we = 1'b1;
        cfg_ch = (j == 3) ? 3'd7 : (j == 9) ? 3'd6 : 3'd5;
        cfg_mode = 2'b00;
        cfg_period = 16'd7;
        cfg_duty = 8'd0;
      end
      tick_edge();
      cfg_we = 1'b0;
      chk("tog_p0", 32'(led[0]), 32'(l0));
      chk("bad_ch", 32'({led[4:3], led[1]}),
          32'({def_tog(ecnt), def_tog(ecnt), pwm_exp(ecnt, 255)}));
    end

    for (int j = 0; j < 8 && (ecnt % 4) != 0; j++) tick_edge();
    chk("tick_pre", 32'(tick), 32'h1);
    cfg_write(3'd0, 2'b01, 16'd2, 8'd0);
    w = ecnt;
    for (int j = 1; j <= 17; j++) begin
      tick_edge();
      chk("tog_wr_tick", 32'(led[0]),
          32'(ecnt >= w + 8 && ecnt < w + 16));
    end

    for (int j = 0; j < 10; j++) tick_edge();
    reset = 1'b1;
    cfg_we = 1'b1;
    cfg_ch = 3'd2;
    cfg_mode = 2'b00;
    tick_edge();
    chk("rst_mid_led", 32'(led), 32'h0);
    chk("rst_mid_tick", 32'(tick), 32'h0);
    reset = 1'b0;
    cfg_we = 1'b0;
    ecnt = 0;
    for (int i = 1; i <= 14; i++) begin
      tick_edge();
      chk("rst2_tick", 32'(tick), 32'((i % 4) == 0));
      chk("rst2_led", 32'(led), def_tog(i) ? 32'h1f : 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
